// File: rtl/xcvr_lock_pkg.sv
// Shared types and constants for the transceiver PLL lock monitor.
package xcvr_lock_pkg;

  localparam int SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    QUALIFY  = 2'd1,
    LOCKED   = 2'd2
  } lock_state_t;

  // Bits needed to hold values 0..value-1; never returns less than 1.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >>> 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/xcvr_lock_monitor_if.sv
// Per-channel lock status bundle between the monitor top and one channel.
// Handshake: none; all signals are level/pulse qualified by clk, pll_locked is raw async.
interface xcvr_lock_monitor_if
  import xcvr_lock_pkg::*;
#(
  parameter int CNT_W = 8
) ();
  logic             pll_locked;
  logic             clear;
  logic             locked;
  logic             sticky;
  logic [CNT_W-1:0] lol_count;
  logic             recal;
  lock_state_t      state;

  modport master (
    output pll_locked, clear,
    input  locked, sticky, lol_count, recal, state
  );

  modport slave (
    input  pll_locked, clear,
    output locked, sticky, lol_count, recal, state
  );
endinterface

// File: rtl/xcvr_lock_chan.sv
// One monitored PLL: synchroniser, lock-qualify FSM, sticky loss flag and loss counter.
// Recalibration timeout is built only when XCVR_LOCK_TIMEOUT_EN is defined.
module xcvr_lock_chan
  import xcvr_lock_pkg::*;
#(
  parameter int DEB_CYCLES     = 1024,
  parameter int CNT_W          = 8,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input logic                 clk_i,
  input logic                 rst_ni,
  xcvr_lock_monitor_if.slave  ch_if
);

  localparam int               DEB_W    = clog2(DEB_CYCLES);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  if (DEB_CYCLES < 2) begin : g_bad_deb
    $error("xcvr_lock_chan: DEB_CYCLES must be at least 2");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("xcvr_lock_chan: TIMEOUT_CYCLES must be at least 2");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  lock_state_t            state_q;
  logic [DEB_W-1:0]       deb_q;
  logic                   locked_q;
  logic                   sticky_q, sticky_d;
  logic [CNT_W-1:0]       lol_cnt_q, lol_cnt_d;
  logic                   loss;

  assign sync = sync_q[SYNC_STAGES-1];
  // Only a drop out of LOCKED counts; glitches during QUALIFY are silently rejected.
  assign loss = (state_q == LOCKED) && !sync;

  always_comb begin
    sticky_d  = sticky_q;
    lol_cnt_d = lol_cnt_q;
    if (loss) begin
      sticky_d = 1'b1;
      if (ch_if.clear) begin
        lol_cnt_d = CNT_W'(1);
      end else if (lol_cnt_q != CNT_MAX) begin
        lol_cnt_d = lol_cnt_q + 1'b1;
      end
    end else if (ch_if.clear) begin
      sticky_d  = 1'b0;
      lol_cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q    <= '0;
      state_q   <= UNLOCKED;
      deb_q     <= '0;
      locked_q  <= 1'b0;
      sticky_q  <= 1'b0;
      lol_cnt_q <= '0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], ch_if.pll_locked};
      locked_q  <= (state_q == LOCKED);
      sticky_q  <= sticky_d;
      lol_cnt_q <= lol_cnt_d;
      case (state_q)
        UNLOCKED: begin
          if (sync) begin
            state_q <= QUALIFY;
            deb_q   <= DEB_W'(1);
          end
        end
        QUALIFY: begin
          if (!sync) begin
            state_q <= UNLOCKED;
            deb_q   <= '0;
          end else if (deb_q == DEB_LAST) begin
            state_q <= LOCKED;
            deb_q   <= '0;
          end else begin
            deb_q <= deb_q + 1'b1;
          end
        end
        LOCKED: begin
          if (!sync) state_q <= UNLOCKED;
        end
        default: begin
          state_q <= UNLOCKED;
          deb_q   <= '0;
        end
      endcase
    end
  end

`ifdef XCVR_LOCK_TIMEOUT_EN
  localparam int              TO_W    = clog2(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] to_q;
  logic            recal_q;

  // Free-runs while not locked, restarting after each request so requests repeat.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      to_q    <= '0;
      recal_q <= 1'b0;
    end else if (state_q == LOCKED) begin
      to_q    <= '0;
      recal_q <= 1'b0;
    end else if (to_q == TO_LAST) begin
      to_q    <= '0;
      recal_q <= 1'b1;
    end else begin
      to_q    <= to_q + 1'b1;
      recal_q <= 1'b0;
    end
  end

  assign ch_if.recal = recal_q;
`else
  assign ch_if.recal = 1'b0;
`endif

  assign ch_if.locked    = locked_q;
  assign ch_if.sticky    = sticky_q;
  assign ch_if.lol_count = lol_cnt_q;
  assign ch_if.state     = state_q;

endmodule

// File: rtl/xcvr_lock_monitor.sv
// Debounced lock monitor for NUM_PLLS transceiver PLLs with aggregate lock and loss statistics.
// Optional recalibration requests: define XCVR_LOCK_TIMEOUT_EN.
module xcvr_lock_monitor #(
  parameter int NUM_PLLS       = 3,
  parameter int DEB_CYCLES     = 1024,
  parameter int CNT_W          = 8,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                      clk_100_clk,
  input  logic                      reset_100_reset_n,
  input  logic [NUM_PLLS-1:0]       pll_locked_in,
  input  logic [NUM_PLLS-1:0]       clear_in,
  output logic [NUM_PLLS-1:0]       pll_locked_out,
  output logic                      all_locked_out,
  output logic [NUM_PLLS-1:0]       lol_sticky_out,
  output logic [NUM_PLLS*CNT_W-1:0] lol_count_out,
  output logic [NUM_PLLS-1:0]       recal_req_out
);

  if (NUM_PLLS < 1 || NUM_PLLS > 32) begin : g_bad_num
    $error("xcvr_lock_monitor: NUM_PLLS must be 1..32");
  end

  for (genvar i = 0; i < NUM_PLLS; i++) begin : g_chan
    xcvr_lock_monitor_if #(.CNT_W(CNT_W)) ch_if ();

    assign ch_if.pll_locked = pll_locked_in[i];
    assign ch_if.clear      = clear_in[i];

    xcvr_lock_chan #(
      .DEB_CYCLES    (DEB_CYCLES),
      .CNT_W         (CNT_W),
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_chan (
      .clk_i (clk_100_clk),
      .rst_ni(reset_100_reset_n),
      .ch_if (ch_if)
    );

    assign pll_locked_out[i]               = ch_if.locked;
    assign lol_sticky_out[i]               = ch_if.sticky;
    assign lol_count_out[i*CNT_W +: CNT_W] = ch_if.lol_count;
    assign recal_req_out[i]                = ch_if.recal;
  end

  logic all_locked_q;

  always_ff @(posedge clk_100_clk or negedge reset_100_reset_n) begin
    if (!reset_100_reset_n) all_locked_q <= 1'b0;
    else                    all_locked_q <= &pll_locked_out;
  end

  assign all_locked_out = all_locked_q;

endmodule

// File: tb/tb_xcvr_lock_monitor.sv
// Directed bench for xcvr_lock_monitor with DEB_CYCLES=16, CNT_W=4, TIMEOUT_CYCLES=50.
module tb_xcvr_lock_monitor;
  import xcvr_lock_pkg::*;

  localparam int NUM_PLLS = 3;
  localparam int DEB      = 16;
  localparam int CNT_W    = 4;
  localparam int TO       = 50;

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b0;
  logic [NUM_PLLS-1:0]       pll_in = '0;
  logic [NUM_PLLS-1:0]       clr = '0;
  logic [NUM_PLLS-1:0]       locked_out;
  logic                      all_out;
  logic [NUM_PLLS-1:0]       sticky_out;
  logic [NUM_PLLS*CNT_W-1:0] count_out;
  logic [NUM_PLLS-1:0]       recal_out;

  int checks   = 0;
  int failures = 0;
  int recal_any_seen = 0;
  int recal1_seen    = 0;

  // clock/reset block
  always #5 clk = ~clk;

  xcvr_lock_monitor #(
    .NUM_PLLS(NUM_PLLS), .DEB_CYCLES(DEB), .CNT_W(CNT_W), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_100_clk      (clk),
    .reset_100_reset_n(rst_n),
    .pll_locked_in    (pll_in),
    .clear_in         (clr),
    .pll_locked_out   (locked_out),
    .all_locked_out   (all_out),
    .lol_sticky_out   (sticky_out),
    .lol_count_out    (count_out),
    .recal_req_out    (recal_out)
  );

  // channel 2 view through the per-channel bundle
  xcvr_lock_monitor_if #(.CNT_W(CNT_W)) ch2_view ();
  assign ch2_view.pll_locked = pll_in[2];
  assign ch2_view.clear      = clr[2];
  assign ch2_view.locked     = locked_out[2];
  assign ch2_view.sticky     = sticky_out[2];
  assign ch2_view.lol_count  = count_out[2*CNT_W +: CNT_W];
  assign ch2_view.recal      = recal_out[2];
  assign ch2_view.state      = dut.g_chan[2].ch_if.state;

  always @(negedge clk) begin
    if (recal_out != '0) recal_any_seen++;
    if (recal_out[1])    recal1_seen++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Returns #1 after the n-th rising edge; inputs driven afterwards hit the next edge.
  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n  = 1'b0;
    pll_in = '0;
    clr    = '0;
    wait_edges(3);
    rst_n = 1'b1;
  endtask

  task automatic lock_then_drop_ch2();
    pll_in[2] = 1'b1;
    wait_edges(DEB + 3);
    pll_in[2] = 1'b0;
    wait_edges(4);
  endtask

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int exp_cnt;
    int p;

    // reset values
    wait_edges(2);
    check("rst_locked", 32'(locked_out), 0);
    check("rst_all",    32'(all_out), 0);
    check("rst_sticky", 32'(sticky_out), 0);
    check("rst_count",  32'(count_out), 0);
    check("rst_recal",  32'(recal_out), 0);
    check("rst_state2", 32'(ch2_view.state), 32'(UNLOCKED));

    // all three held high from edge 0
    rst_n  = 1'b1;
    pll_in = 3'b111;
    wait_edges(18);
    check("t1_locked_e17", 32'(locked_out), 0);
    wait_edges(1);
    check("t1_locked_e18", 32'(locked_out), 3'b111);
    check("t1_all_e18",    32'(all_out), 0);
    wait_edges(1);
    check("t1_all_e19",    32'(all_out), 1);
    check("t1_sticky",     32'(sticky_out), 0);
    check("t1_count",      32'(count_out), 0);
    check("t1_state2",     32'(ch2_view.state), 32'(LOCKED));

    // ch1 one-cycle glitch during QUALIFY
    apply_reset();
    pll_in = 3'b011;
    wait_edges(5);
    pll_in[1] = 1'b0;
    wait_edges(1);
    pll_in[1] = 1'b1;
    wait_edges(13);
    check("t2_locked_e18", 32'(locked_out), 3'b001);
    wait_edges(5);
    check("t2_locked_e23", 32'(locked_out), 3'b001);
    wait_edges(1);
    check("t2_locked_e24", 32'(locked_out), 3'b011);
    check("t2_sticky",     32'(sticky_out), 0);
    check("t2_count",      32'(count_out), 0);

    // ch2 lock/drop 20 times, counter saturates at 15
    for (int i = 0; i < 20; i++) begin
      pll_in[2] = 1'b1;
      wait_edges(DEB + 3);
      check("t3_locked", 32'(locked_out), 3'b111);
      wait_edges(1);
      check("t3_all_hi", 32'(all_out), 1);
      pll_in[2] = 1'b0;
      wait_edges(3);
      exp_cnt = (i + 1 > 15) ? 15 : i + 1;
      check("t3_count", 32'(ch2_view.lol_count), 32'(exp_cnt));
      check("t3_sticky", 32'(ch2_view.sticky), 1);
      wait_edges(1);
      check("t3_locked_lo", 32'(ch2_view.locked), 0);
      wait_edges(1);
      check("t3_all_lo", 32'(all_out), 0);
    end
    check("t3_other_counts", 32'(count_out[2*CNT_W-1:0]), 0);

    // lone clear, then clear coincident with a loss event at count 5
    clr[2] = 1'b1;
    wait_edges(1);
    clr[2] = 1'b0;
    check("t4_clr_count",  32'(ch2_view.lol_count), 0);
    check("t4_clr_sticky", 32'(ch2_view.sticky), 0);
    check("t4_clr_locked", 32'(locked_out), 3'b011);
    repeat (5) lock_then_drop_ch2();
    check("t4_count5", 32'(ch2_view.lol_count), 5);
    pll_in[2] = 1'b1;
    wait_edges(DEB + 3);
    pll_in[2] = 1'b0;
    wait_edges(2);
    clr[2] = 1'b1;
    wait_edges(1);
    check("t4_both_count",  32'(ch2_view.lol_count), 1);
    check("t4_both_sticky", 32'(ch2_view.sticky), 1);
    wait_edges(1);
    clr[2] = 1'b0;
    check("t4_next_count",  32'(ch2_view.lol_count), 0);
    check("t4_next_sticky", 32'(ch2_view.sticky), 0);
    check("t4_next_locked", 32'(locked_out), 3'b011);

    // asynchronous reset while ch0 is mid-qualify and ch1 locked
    apply_reset();
    pll_in = 3'b010;
    wait_edges(DEB + 3);
    check("t5_pre_locked", 32'(locked_out), 3'b010);
    pll_in[0] = 1'b1;
    wait_edges(12);
    rst_n = 1'b0;
    #1;
    check("t5_async_locked", 32'(locked_out), 0);
    check("t5_async_all",    32'(all_out), 0);
    check("t5_async_count",  32'(count_out), 0);
    wait_edges(2);
    rst_n = 1'b1;
    wait_edges(18);
    check("t5_requal_e17", 32'(locked_out), 0);
    wait_edges(1);
    check("t5_requal_e18", 32'(locked_out), 3'b011);
    check("t5_sticky",     32'(sticky_out), 0);
    check("t5_count",      32'(count_out), 0);

`ifdef XCVR_LOCK_TIMEOUT_EN
    // recalibration requests every 50 cycles while unlocked
    apply_reset();
    wait_edges(49);
    check("t6_recal_e48", 32'(recal_out), 0);
    wait_edges(1);
    check("t6_recal_e49", 32'(recal_out), 3'b111);
    wait_edges(1);
    check("t6_recal_e50", 32'(recal_out), 0);
    wait_edges(49);
    check("t6_recal_e99", 32'(recal_out), 3'b111);
    pll_in[1] = 1'b1;
    wait_edges(DEB + 3);
    check("t6_ch1_locked", 32'(locked_out), 3'b010);
    p = recal1_seen;
    wait_edges(150);
    check("t6_ch1_no_recal", 32'(recal1_seen), 32'(p));
    check("t6_ch0_recal_seen", 32'(recal_any_seen > 3), 1);
`else
    p = 0;
    wait_edges(TO * 3);
    check("t6_recal_never", 32'(recal_any_seen), 32'(p));
    check("t6_recal_now",   32'(recal_out), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
